axi_lite_slave: RTL and testbench

AXI4-Lite memory-mapped responder, the slave end of the five-channel master link. It accepts write address/data, commits byte-strobed writes into a local 1024 x 32 word memory, returns a write response, and serves single-word reads. It sits behind the master's 11-bit address bus; bit 10 selects the slave, and bits 9:0 are the word index.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/slave_mem.sv | 34 +++
 rtl/axi_lite_slave.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_slave.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and widths for the AXI4-Lite responder: response codes,
// bus widths and the write/read FSM state encodings.
package axi_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_COMMIT,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_RESP
  } rstate_t;

  function automatic resp_t decode_resp(input logic i_sel, input logic i_id);
    return (i_sel == i_id) ? OKAY : DECERR;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Word-addressed storage: byte-enabled single-cycle write port and a
// registered read port. Not reset; a same-edge read sees the pre-write word.
module slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [STRB_W-1:0]     i_wstrb,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_slave.sv
// AXI4-Lite responder: independent write (collect/commit/respond) and read
// (idle/fetch/respond) FSMs over a local word memory, bit 10 selects slave.
module axi_lite_slave
  import axi_pkg::*;
#(
  parameter logic        SLAVE_ID       = 1'b0,
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);

  wstate_t             r_wstate;
  logic                r_aw_full;
  logic                r_w_full;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic [STRB_W-1:0]   r_w_strb;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  resp_t               r_bresp;

  rstate_t             r_rstate;
  logic                r_fetch_done;
  logic [ADDR_W-1:0]   r_ar_addr;
  logic                r_arready;
  logic                r_rvalid;
  resp_t               r_rresp;
  logic [DATA_W-1:0]   r_rdata;

  resp_t               w_aw_resp;
  resp_t               w_ar_resp;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [DATA_W-1:0]   w_mem_rdata;

  assign w_aw_resp = decode_resp(r_aw_addr[ADDR_W-1], SLAVE_ID);
  assign w_ar_resp = decode_resp(r_ar_addr[ADDR_W-1], SLAVE_ID);
  assign w_mem_we  = (r_wstate == W_COMMIT) && (w_aw_resp == OKAY);
  assign w_mem_re  = (r_rstate == R_FETCH) && !r_fetch_done;

  slave_mem #(
    .DEPTH_LOG2(MEM_DEPTH_LOG2)
  ) u_mem (
    .i_clk   (ACLK),
    .i_we    (w_mem_we),
    .i_waddr (r_aw_addr[MEM_DEPTH_LOG2-1:0]),
    .i_wdata (r_w_data),
    .i_wstrb (r_w_strb),
    .i_re    (w_mem_re),
    .i_raddr (r_ar_addr[MEM_DEPTH_LOG2-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // READYs start low in reset and rise on the first edge with an empty hold.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate  <= W_COLLECT;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      case (r_wstate)
        W_COLLECT: begin
          if (r_aw_full && r_w_full) r_wstate <= W_COMMIT;
          if (r_awready && AWVALID) begin
            r_aw_addr <= AWADDR;
            r_aw_full <= 1'b1;
            r_awready <= 1'b0;
          end else if (!r_aw_full) begin
            r_awready <= 1'b1;
          end
          if (r_wready && WVALID) begin
            r_w_data <= WDATA;
            r_w_strb <= WSTRB;
            r_w_full <= 1'b1;
            r_wready <= 1'b0;
          end else if (!r_w_full) begin
            r_wready <= 1'b1;
          end
        end
        W_COMMIT: begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_aw_resp;
          r_wstate <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_COLLECT;
          end
        end
        default: r_wstate <= W_COLLECT;
      endcase
    end
  end

  // Fetch spends one edge reading the memory and one registering the beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate     <= R_IDLE;
      r_fetch_done <= 1'b0;
      r_ar_addr    <= '0;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rresp      <= OKAY;
      r_rdata      <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready && ARVALID) begin
            r_ar_addr    <= ARADDR;
            r_arready    <= 1'b0;
            r_fetch_done <= 1'b0;
            r_rstate     <= R_FETCH;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_FETCH: begin
          if (!r_fetch_done) begin
            r_fetch_done <= 1'b1;
          end else begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_resp;
            r_rdata  <= (w_ar_resp == OKAY) ? w_mem_rdata : '0;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Bench for axi_lite_slave: transaction-timing reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_axi_lite_slave;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [10:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [10:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_lite_slave #(
    .SLAVE_ID       (1'b0),
    .MEM_DEPTH_LOG2 (10)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within bound at %0t", name, $time);
  endtask

  // Reference model: transaction timing from the handshake edges.
  bit          m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  bit          m_rdata_known;
  bit          m_aw_have, m_w_have, m_ar_have;
  logic [10:0] m_aw_addr, m_ar_addr;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  longint      m_cyc = 0;
  longint      m_wdue = -1, m_rsnap = -1, m_rdue = -1;
  logic [31:0] m_snap;
  bit          m_snap_known;
  logic [31:0] mem_m [1024];
  bit          known [1024];

  always @(posedge ACLK or posedge ARESET) begin : model
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int idx;
    if (ARESET) begin
      m_awready = 0; m_wready = 0; m_arready = 0;
      m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
      m_rdata_known = 1;
      m_aw_have = 0; m_w_have = 0; m_ar_have = 0;
      m_wdue = -1; m_rsnap = -1; m_rdue = -1;
    end else begin
      aw_hs = m_awready && AWVALID;
      w_hs  = m_wready && WVALID;
      b_hs  = m_bvalid && BREADY;
      ar_hs = m_arready && ARVALID;
      r_hs  = m_rvalid && RREADY;
      m_cyc++;
      if (m_rsnap == m_cyc) begin
        m_snap = mem_m[m_ar_addr[9:0]];
        m_snap_known = known[m_ar_addr[9:0]];
        m_rsnap = -1;
      end
      if (m_wdue == m_cyc) begin
        idx = int'(m_aw_addr[9:0]);
        if (m_aw_addr[10] == 1'b0) begin
          for (int b = 0; b < 4; b++)
            if (m_w_strb[b]) mem_m[idx][8*b +: 8] = m_w_data[8*b +: 8];
          if (m_w_strb == 4'hF) known[idx] = 1;
        end
        m_bvalid = 1;
        m_bresp = m_aw_addr[10] ? 2'b11 : 2'b00;
        m_wdue = -1;
      end
      if (m_rdue == m_cyc) begin
        m_rvalid = 1;
        m_rresp = m_ar_addr[10] ? 2'b11 : 2'b00;
        m_rdata = m_ar_addr[10] ? 32'h0 : m_snap;
        m_rdata_known = m_ar_addr[10] || m_snap_known;
        m_rdue = -1;
      end
      if (b_hs) begin m_bvalid = 0; m_aw_have = 0; m_w_have = 0; end
      if (r_hs) begin m_rvalid = 0; m_ar_have = 0; end
      if (aw_hs) begin m_aw_have = 1; m_aw_addr = AWADDR; end
      if (w_hs) begin m_w_have = 1; m_w_data = WDATA; m_w_strb = WSTRB; end
      if ((aw_hs || w_hs) && m_aw_have && m_w_have) m_wdue = m_cyc + 2;
      if (ar_hs) begin
        m_ar_have = 1; m_ar_addr = ARADDR;
        m_rsnap = m_cyc + 1; m_rdue = m_cyc + 2;
      end
      m_awready = !m_aw_have;
      m_wready  = !m_w_have;
      m_arready = !m_ar_have;
    end
  end

  always @(posedge ACLK) begin
    #4;
    chk("awready", AWREADY, m_awready);
    chk("wready", WREADY, m_wready);
    chk("arready", ARREADY, m_arready);
    chk("bvalid", BVALID, m_bvalid);
    chk("rvalid", RVALID, m_rvalid);
    if (m_bvalid) chk("bresp", BRESP, m_bresp);
    if (m_rvalid) begin
      chk("rresp", RRESP, m_rresp);
      if (m_rdata_known) chk("rdata", RDATA, m_rdata);
    end
    if (ARESET) begin
      chk("rst_bresp", BRESP, 0);
      chk("rst_rresp", RRESP, 0);
      chk("rst_rdata", RDATA, 0);
    end
  end

  // Drivers: inputs change at negedge; READY/VALID sampled 1 time unit later.
  task automatic aw_send(input logic [10:0] a);
    AWADDR = a; AWVALID = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (AWREADY) begin @(negedge ACLK); AWVALID = 1'b0; return; end
      @(negedge ACLK);
    end
    AWVALID = 1'b0;
    timeout("aw_handshake");
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (WREADY) begin @(negedge ACLK); WVALID = 1'b0; return; end
      @(negedge ACLK);
    end
    WVALID = 1'b0;
    timeout("w_handshake");
  endtask

  task automatic ar_send(input logic [10:0] a);
    ARADDR = a; ARVALID = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (ARREADY) begin @(negedge ACLK); ARVALID = 1'b0; return; end
      @(negedge ACLK);
    end
    ARVALID = 1'b0;
    timeout("ar_handshake");
  endtask

  task automatic wait_b(output logic [1:0] resp);
    resp = 2'bxx;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (BVALID && BREADY) begin resp = BRESP; @(negedge ACLK); return; end
      @(negedge ACLK);
    end
    timeout("b_handshake");
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    data = 'x; resp = 2'bxx;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (RVALID && RREADY) begin data = RDATA; resp = RRESP; @(negedge ACLK); return; end
      @(negedge ACLK);
    end
    timeout("r_handshake");
  endtask

  task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    fork
      aw_send(a);
      w_send(d, s);
    join
    wait_b(resp);
  endtask

  task automatic do_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] resp);
    ar_send(a);
    wait_r(d, resp);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  bit rnd_done = 0;

  initial begin : stim
    logic [1:0]  resp, resp2;
    logic [31:0] rd;
    bit          seen;

    #2 ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("ready_before_first_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    chk("ready_after_first_edge", {AWREADY, WREADY, ARREADY}, 3'b111);
    BREADY = 1'b1; RREADY = 1'b1;

    for (int i = 0; i < 16; i++) do_write(11'(i), 32'h0, 4'hF, resp);

    // Same-cycle AW/W, then BVALID two edges after the handshake.
    fork
      aw_send(11'h005);
      w_send(32'hDEADBEEF, 4'hF);
    join
    #1 chk("bvalid_edge_n", BVALID, 0);
    @(negedge ACLK); #1 chk("bvalid_edge_n1", BVALID, 0);
    @(negedge ACLK); #1 chk("bvalid_edge_n2", BVALID, 1);
    wait_b(resp);
    chk("t1_bresp", resp, 2'b00);
    do_read(11'h005, rd, resp);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rresp", resp, 2'b00);

    // W three cycles ahead of AW, response back-pressured.
    BREADY = 1'b0;
    fork
      w_send(32'h12345678, 4'hF);
      begin repeat (3) @(negedge ACLK); aw_send(11'h00A); end
    join
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (BVALID) seen = 1; else @(negedge ACLK);
    end
    if (!seen) timeout("t2_bvalid");
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK); #1;
      chk("t2_bvalid_hold", BVALID, 1);
      chk("t2_bresp_hold", BRESP, 2'b00);
      chk("t2_ready_low", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1'b1;
    wait_b(resp);
    do_read(11'h00A, rd, resp);
    chk("t2_rdata", rd, 32'h12345678);

    // Byte-strobe merge.
    do_write(11'h003, 32'hAABBCCDD, 4'hF, resp);
    do_write(11'h003, 32'h11223344, 4'b0101, resp);
    chk("t3_bresp", resp, 2'b00);
    do_read(11'h003, rd, resp);
    chk("t3_rdata", rd, 32'hAA22CC44);

    // Decode error and empty strobe.
    do_write(11'h405, 32'h55555555, 4'hF, resp);
    chk("t4_bresp", resp, 2'b11);
    do_write(11'h005, 32'h0, 4'h0, resp);
    chk("t4_strb0_bresp", resp, 2'b00);
    do_read(11'h005, rd, resp);
    chk("t4_unchanged", rd, 32'hDEADBEEF);
    do_read(11'h405, rd, resp);
    chk("t4_rresp", resp, 2'b11);
    chk("t4_rdata", rd, 32'h0);

    // Concurrent read and write of the same word: old data returned.
    fork
      do_write(11'h007, 32'hFFFF0000, 4'hF, resp2);
      do_read(11'h007, rd, resp);
    join
    chk("t5_old", rd, 32'h0);
    do_read(11'h007, rd, resp);
    chk("t5_new", rd, 32'hFFFF0000);

    // Reset with both responses pending.
    BREADY = 1'b0; RREADY = 1'b0;
    fork
      begin aw_send(11'h00C); end
      begin w_send(32'hCAFEF00D, 4'hF); end
      begin ar_send(11'h005); end
    join
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #1;
      if (BVALID && RVALID) seen = 1; else @(negedge ACLK);
    end
    if (!seen) timeout("t6_pending");
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    chk("t6_async_bvalid", BVALID, 0);
    chk("t6_async_rvalid", RVALID, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    #1 chk("t6_ready_low", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    chk("t6_ready_back", {AWREADY, WREADY, ARREADY}, 3'b111);
    do_read(11'h00C, rd, resp);
    chk("t6_committed", rd, 32'hCAFEF00D);

    // Reset between handshake and commit: the write is dropped.
    fork
      aw_send(11'h00D);
      w_send(32'h0BADF00D, 4'hF);
    join
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    do_read(11'h00D, rd, resp);
    chk("t6_aborted", rd, 32'h0);

    // Random concurrent traffic.
    fork
      begin
        fork
          begin
            for (int n = 0; n < 120; n++) begin
              logic [10:0] a;
              logic [1:0]  r;
              a = {($urandom_range(0, 4) == 0), 10'($urandom_range(0, 15))};
              fork
                begin repeat ($urandom_range(0, 3)) @(negedge ACLK); aw_send(a); end
                begin repeat ($urandom_range(0, 3)) @(negedge ACLK); w_send($urandom, 4'($urandom)); end
              join
              wait_b(r);
            end
          end
          begin
            for (int n = 0; n < 120; n++) begin
              logic [10:0] a;
              logic [31:0] d;
              logic [1:0]  r;
              a = {($urandom_range(0, 4) == 0), 10'($urandom_range(0, 15))};
              repeat ($urandom_range(0, 3)) @(negedge ACLK);
              do_read(a, d, r);
            end
          end
        join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin @(negedge ACLK); BREADY = ($urandom_range(0, 2) != 0); end
      end
      begin
        while (!rnd_done) begin @(negedge ACLK); RREADY = ($urandom_range(0, 2) != 0); end
      end
    join
    BREADY = 1'b1; RREADY = 1'b1;
    repeat (5) @(negedge ACLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
